// File: rtl/pencere_denetleyici.sv
// Streaming 3x3 window scheduler: raster pixels in, one zero-padded window per pixel out, registered.
// The centre trails the newest input by IMG_W+1 pixels; input is stalled while a held window is unaccepted.
module pencere_denetleyici #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int DW    = 8,
    parameter logic [DW-1:0] PAD = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          basla_i,
    input  logic [DW-1:0] veri_i,
    input  logic          veri_gecerli_i,
    output logic          veri_hazir_o,
    output logic [DW-1:0] g0_o,
    output logic [DW-1:0] g1_o,
    output logic [DW-1:0] g2_o,
    output logic [DW-1:0] g3_o,
    output logic [DW-1:0] g4_o,
    output logic [DW-1:0] g5_o,
    output logic [DW-1:0] g6_o,
    output logic [DW-1:0] g7_o,
    output logic [DW-1:0] g8_o,
    output logic [DW-1:0] merkez_o,
    output logic          pencere_gecerli_o,
    input  logic          pencere_hazir_i,
    output logic          son_pencere_o,
    output logic          mesgul_o,
    output logic          bitti_o
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int SHN  = 2 * IMG_W + 2;
    localparam int SW   = $clog2(SHN + 1);
    localparam int CW   = $clog2(NPIX + 1);
    localparam int RW   = $clog2(IMG_H + 1);
    localparam int KW   = $clog2(IMG_W + 1);

    localparam logic [2:0] ST_BOSTA  = 3'd0;
    localparam logic [2:0] ST_DOLDUR = 3'd1;
    localparam logic [2:0] ST_AKIS   = 3'd2;
    localparam logic [2:0] ST_BOSALT = 3'd3;
    localparam logic [2:0] ST_BITTI  = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [CW-1:0]            in_cnt_q, in_cnt_d;
    logic [RW-1:0]            row_q, row_d;
    logic [KW-1:0]            col_q, col_d;
    logic                     vld_q, vld_d;
    logic                     son_q, son_d;
    logic [8:0][DW-1:0]       win_q, win_d;
    logic [SHN-1:0][DW-1:0]   sh_q, sh_d;

    logic                     hazir, kabul, cikis, uret_bosalt, uret, kaydir;
    logic [DW-1:0]            yeni;
    logic [SHN:0][DW-1:0]     src;
    logic [8:0][DW-1:0]       tap;
    logic                     tap_ok;
    logic                     satir_ust, satir_alt, sutun_sol, sutun_sag, son_konum;

    // Tap t sits at (t/3-1, t%3-1) around the centre; src[0] is the newest pixel.
    function automatic int tap_idx(input int t);
        return IMG_W + 1 - ((t / 3) - 1) * IMG_W - ((t % 3) - 1);
    endfunction

    assign hazir       = en_i && ((state_q == ST_DOLDUR) ||
                         ((state_q == ST_AKIS) && (!vld_q || pencere_hazir_i)));
    assign kabul       = hazir && veri_gecerli_i;
    assign cikis       = en_i && vld_q && pencere_hazir_i;
    assign uret_bosalt = en_i && (state_q == ST_BOSALT) && (!vld_q || pencere_hazir_i)
                         && !(vld_q && son_q);
    assign uret        = (kabul && (state_q == ST_AKIS)) || uret_bosalt;
    assign kaydir      = kabul || uret_bosalt;
    assign yeni        = (state_q == ST_BOSALT) ? PAD : veri_i;
    assign src         = {sh_q, yeni};

    // Edge masks come from the centre counters, so stale or wrapped buffer data never shows.
    assign satir_ust = (row_q != '0);
    assign satir_alt = (row_q != RW'(IMG_H - 1));
    assign sutun_sol = (col_q != '0);
    assign sutun_sag = (col_q != KW'(IMG_W - 1));
    assign son_konum = !satir_alt && !sutun_sag;

    always_comb begin
        tap    = '0;
        tap_ok = 1'b0;
        for (int t = 0; t < 9; t++) begin
            tap_ok = 1'b1;
            if (t < 3)       tap_ok = tap_ok && satir_ust;
            if (t >= 6)      tap_ok = tap_ok && satir_alt;
            if (t % 3 == 0)  tap_ok = tap_ok && sutun_sol;
            if (t % 3 == 2)  tap_ok = tap_ok && sutun_sag;
            tap[t] = tap_ok ? src[SW'(tap_idx(t))] : PAD;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_cnt_d = in_cnt_q;
        row_d    = row_q;
        col_d    = col_q;
        vld_d    = vld_q;
        son_d    = son_q;
        win_d    = win_q;
        sh_d     = sh_q;

        if (kaydir) begin
            sh_d = src[SHN-1:0];
        end

        if (cikis) begin
            vld_d = 1'b0;
            son_d = 1'b0;
        end

        if (uret) begin
            vld_d = 1'b1;
            win_d = tap;
            son_d = son_konum;
            if (!sutun_sag) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            ST_BOSTA: begin
                if (en_i && basla_i) begin
                    state_d  = ST_DOLDUR;
                    in_cnt_d = '0;
                    row_d    = '0;
                    col_d    = '0;
                    vld_d    = 1'b0;
                    son_d    = 1'b0;
                end
            end
            ST_DOLDUR: begin
                if (kabul) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == CW'(IMG_W)) state_d = ST_AKIS;
                end
            end
            ST_AKIS: begin
                if (kabul) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == CW'(NPIX - 1)) state_d = ST_BOSALT;
                end
            end
            ST_BOSALT: begin
                if (cikis && son_q) state_d = ST_BITTI;
            end
            ST_BITTI: begin
                if (en_i) state_d = ST_BOSTA;
            end
            default: state_d = ST_BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_BOSTA;
            in_cnt_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
            vld_q    <= 1'b0;
            son_q    <= 1'b0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            row_q    <= row_d;
            col_q    <= col_d;
            vld_q    <= vld_d;
            son_q    <= son_d;
            win_q    <= win_d;
        end
    end

    // Row buffer holds data only; padding makes a reset of it unnecessary.
    always_ff @(posedge clk_i) begin
        sh_q <= sh_d;
    end

    assign veri_hazir_o      = hazir;
    assign g0_o              = win_q[0];
    assign g1_o              = win_q[1];
    assign g2_o              = win_q[2];
    assign g3_o              = win_q[3];
    assign g4_o              = win_q[4];
    assign g5_o              = win_q[5];
    assign g6_o              = win_q[6];
    assign g7_o              = win_q[7];
    assign g8_o              = win_q[8];
    assign merkez_o          = win_q[4];
    assign pencere_gecerli_o = vld_q;
    assign son_pencere_o     = son_q;
    assign mesgul_o          = (state_q == ST_DOLDUR) || (state_q == ST_AKIS) || (state_q == ST_BOSALT);
    assign bitti_o           = (state_q == ST_BITTI);

endmodule

// File: tb/tb_pencere_denetleyici.sv
// Directed bench for pencere_denetleyici: a 4x3 instance for the handshake cases and a default 320x240 instance.
module tb_pencere_denetleyici;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int BW = 320;
    localparam int BH = 240;
    localparam int BN = BW * BH;

    typedef logic [72:0] win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       s_en, s_basla, s_gec, s_hazir, s_pgec, s_phaz, s_son, s_mesgul, s_bitti;
    logic [7:0] s_veri, s_merkez, s_g0, s_g1, s_g2, s_g3, s_g4, s_g5, s_g6, s_g7, s_g8;
    logic       b_en, b_basla, b_gec, b_hazir, b_pgec, b_phaz, b_son, b_mesgul, b_bitti;
    logic [7:0] b_veri, b_merkez, b_g0, b_g1, b_g2, b_g3, b_g4, b_g5, b_g6, b_g7, b_g8;

    win_t        s_win, b_win;
    logic [84:0] s_all, b_all;
    assign s_win = {s_son, s_g0, s_g1, s_g2, s_g3, s_g4, s_g5, s_g6, s_g7, s_g8};
    assign b_win = {b_son, b_g0, b_g1, b_g2, b_g3, b_g4, b_g5, b_g6, b_g7, b_g8};
    assign s_all = {s_hazir, s_pgec, s_mesgul, s_bitti, s_merkez, s_win};
    assign b_all = {b_hazir, b_pgec, b_mesgul, b_bitti, b_merkez, b_win};

    pencere_denetleyici #(.IMG_W(W), .IMG_H(H), .DW(8), .PAD(8'h00)) u_kucuk (
        .clk_i(clk), .rst_i(rst), .en_i(s_en), .basla_i(s_basla),
        .veri_i(s_veri), .veri_gecerli_i(s_gec), .veri_hazir_o(s_hazir),
        .g0_o(s_g0), .g1_o(s_g1), .g2_o(s_g2), .g3_o(s_g3), .g4_o(s_g4),
        .g5_o(s_g5), .g6_o(s_g6), .g7_o(s_g7), .g8_o(s_g8), .merkez_o(s_merkez),
        .pencere_gecerli_o(s_pgec), .pencere_hazir_i(s_phaz), .son_pencere_o(s_son),
        .mesgul_o(s_mesgul), .bitti_o(s_bitti)
    );

    pencere_denetleyici u_buyuk (
        .clk_i(clk), .rst_i(rst), .en_i(b_en), .basla_i(b_basla),
        .veri_i(b_veri), .veri_gecerli_i(b_gec), .veri_hazir_o(b_hazir),
        .g0_o(b_g0), .g1_o(b_g1), .g2_o(b_g2), .g3_o(b_g3), .g4_o(b_g4),
        .g5_o(b_g5), .g6_o(b_g6), .g7_o(b_g7), .g8_o(b_g8), .merkez_o(b_merkez),
        .pencere_gecerli_o(b_pgec), .pencere_hazir_i(b_phaz), .son_pencere_o(b_son),
        .mesgul_o(b_mesgul), .bitti_o(b_bitti)
    );

    int   errors = 0;
    int   checks = 0;
    int   t0 = 0;
    int   s_cnt = 0;
    int   b_cnt = 0;
    win_t s_q[$];
    win_t b_q[$];
    win_t s_exp, b_exp;

    // Reference window: small frame holds pixel value index+1, large frame is all 255.
    function automatic win_t exp_win(input int w, input int h, input int r, input int c, input bit big);
        win_t x;
        int   rr, cc, v;
        x     = '0;
        x[72] = (r == h - 1) && (c == w - 1);
        for (int t = 0; t < 9; t++) begin
            rr = r + t / 3 - 1;
            cc = c + t % 3 - 1;
            if (rr < 0 || rr >= h || cc < 0 || cc >= w) v = 0;
            else v = big ? 255 : rr * w + cc + 1;
            x[71 - 8 * t -: 8] = v[7:0];
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic new_small();
        s_q.delete();
        s_cnt = 0;
        for (int k = 0; k < N; k++) s_q.push_back(exp_win(W, H, k / W, k % W, 1'b0));
    endtask

    task automatic run_small(input int npix, input bit toggle, input bit gap_mode);
        int i, guard;
        bit acc, gap, basla_done, en_done;
        i = 0; guard = 0; gap = 0; basla_done = 0; en_done = 0;
        t0 = cyc;
        s_basla = 1'b1;
        while (i < npix && guard < 300) begin
            s_veri = 8'(i + 1);
            s_gec  = toggle ? ~gap : 1'b1;
            @(negedge clk);
            acc = s_gec && s_hazir;
            @(posedge clk);
            #1;
            s_basla = 1'b0;
            if (acc) i++;
            gap = ~gap;
            guard++;
            if (gap_mode && i == 3 && !basla_done) begin
                basla_done = 1;
                s_basla    = 1'b1;
            end
            if (gap_mode && i == 7 && !en_done) begin
                en_done = 1;
                s_en    = 1'b0;
                @(negedge clk);
                chk("en_low_hazir", 96'(s_hazir), 96'(0));
                repeat (5) @(posedge clk);
                #1;
                chk("en_low_hold", 96'({s_pgec, s_win}), 96'({1'b1, exp_win(W, H, 0, 1, 1'b0)}));
                s_en = 1'b1;
            end
        end
        s_gec = 1'b0;
        checks++;
        assert (i == npix) else begin
            errors++;
            $error("FAIL feed_timeout accepted=%0d exp=%0d", i, npix);
        end
    endtask

    task automatic wait_done(input bit big, input int exp_cyc, input int exp_n, input int budget);
        bit seen;
        int d;
        seen = 0;
        d    = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (big ? b_bitti : s_bitti) begin
                seen = 1;
                d    = cyc - t0;
            end
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL done_timeout got=0 exp=1");
        end
        if (seen) begin
            if (exp_cyc >= 0) chk("frame_cycles", 96'(d), 96'(exp_cyc));
            chk("mesgul_at_bitti", 96'(big ? b_mesgul : s_mesgul), 96'(0));
            @(negedge clk);
            chk("bitti_single", 96'(big ? b_bitti : s_bitti), 96'(0));
        end
        chk("window_count", 96'(big ? b_cnt : s_cnt), 96'(exp_n));
        chk("queue_empty", 96'(big ? b_q.size() : s_q.size()), 96'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        s_en = 1'b1; s_basla = 1'b0; s_gec = 1'b0; s_veri = 8'h00; s_phaz = 1'b1;
        b_en = 1'b1; b_basla = 1'b0; b_gec = 1'b0; b_veri = 8'h00; b_phaz = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (!rst && s_en && s_pgec && s_phaz) begin
                    if (s_q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL s_extra_window got=%0h exp=none", s_win);
                    end else begin
                        s_exp = s_q.pop_front();
                        chk($sformatf("s_win%0d", s_cnt), 96'(s_win), 96'(s_exp));
                        chk("s_merkez", 96'(s_merkez), 96'(s_exp[39:32]));
                    end
                    s_cnt++;
                end
            end
            forever begin
                @(negedge clk);
                if (!rst && b_en && b_pgec && b_phaz) begin
                    if (b_q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL b_extra_window got=%0h exp=none", b_win);
                    end else begin
                        b_exp = b_q.pop_front();
                        chk("b_win", 96'(b_win), 96'(b_exp));
                    end
                    b_cnt++;
                end
            end
        join_none

        repeat (2) @(negedge clk);
        chk("reset_small", 96'(s_all), 96'(0));
        chk("reset_big", 96'(b_all), 96'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Continuous flow
        new_small();
        run_small(N, 1'b0, 1'b0);
        wait_done(1'b0, N + W + 3, N, 100);

        // Consumer stall on window 6, which appears right after the last accept
        new_small();
        run_small(N, 1'b0, 1'b0);
        chk("stall_count", 96'(s_cnt), 96'(6));
        chk("mesgul_busy", 96'(s_mesgul), 96'(1));
        s_phaz = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", 96'({s_pgec, s_win}), 96'({1'b1, exp_win(W, H, 1, 2, 1'b0)}));
            chk("stall_hazir", 96'(s_hazir), 96'(0));
            @(posedge clk);
        end
        #1;
        s_phaz = 1'b1;
        wait_done(1'b0, N + W + 3 + 3, N, 100);

        // Toggling input valid
        new_small();
        run_small(N, 1'b1, 1'b0);
        wait_done(1'b0, -1, N, 100);

        // Reset mid-frame, then a fresh frame
        new_small();
        run_small(7, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_small", 96'(s_all), 96'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        s_q.delete();
        s_cnt = 0;
        @(posedge clk); #1;
        new_small();
        run_small(N, 1'b0, 1'b0);
        wait_done(1'b0, N + W + 3, N, 100);

        // Stray basla_i mid-frame and five cycles of en_i low
        new_small();
        run_small(N, 1'b0, 1'b1);
        wait_done(1'b0, N + W + 3 + 5, N, 100);

        // Full-size frame of 255s
        b_q.delete();
        b_cnt = 0;
        for (int k = 0; k < BN; k++) b_q.push_back(exp_win(BW, BH, k / BW, k % BW, 1'b1));
        t0      = cyc;
        b_basla = 1'b1;
        b_gec   = 1'b1;
        b_veri  = 8'hFF;
        @(posedge clk); #1;
        b_basla = 1'b0;
        wait_done(1'b1, BN + BW + 3, BN, BN + BW + 100);
        b_gec = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
